mod10_counter: RTL and testbench
================================

Name: mod10_counter

Overview:
- Synchronous decade (modulo-10) counter producing a 4-bit count value 0..9 that wraps.
- Used as a timing/sequencing primitive and cascadable as a BCD digit stage via terminal-count output.
- Supports enable, up/down direction and synchronous parallel load.

Parameters:
- MODULUS, 10, number of states; count range 0..MODULUS-1.
- WIDTH, 4, count width; must satisfy 2**WIDTH >= MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- en  input  1  count enable; integrations that tie it off tie it to 1.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  registered current count.
- tc  output  1  terminal count, combinational.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Reset: the port is named rst. Reset is synchronous and active-low: rst sampled 0 at a clk edge forces count=0. tc then evaluates from count=0.
- Priority per edge: reset > load > en > hold.
- Load (load=1): count <= load_val if load_val < MODULUS. Otherwise count <= 0.
  - Load works regardless of en and up_dn.
- Count (en=1, load=0):
  - Up: count+1, with 9 -> 0 wrap.
  - Down: count-1, with 0 -> 9 wrap.
- Hold: en=0 and load=0 leaves count unchanged.
- Out-of-range state: count never leaves 0..MODULUS-1. Any illegal value recovers to 0 on the next enabled edge.
- tc = en & ~load & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)).
  - Zero latency, so it can drive the next stage's en.
- Latency: count reflects the action one clock after it is sampled. No handshake.
- Reset asserted mid-count: count is 0 after that edge. Counting resumes from 0 on the first edge with rst=1.
- Simultaneous load and en: load wins.

Optional Feature:
- Macro MOD10_SEGOUT_EN.
- Defined: adds output seg (7 bits, active-high, bit order gfedcba), registered from the next count value so it aligns with count in the same cycle.
  - Digits 0..9 use standard seven-segment encoding.
  - Reset value is the pattern for 0 (0111111).
- Undefined: no seg port and no decoder logic. All other behaviour is identical.

Decomposition:
- Package mod10_pkg holds:
  - default MODULUS/WIDTH constants;
  - a direction enum (DIR_DOWN=0, DIR_UP=1);
  - the 10-entry seven-segment pattern constant array.
- One natural sub-module: bcd_to_7seg, a pure combinational 4-bit to 7-bit decoder. It is instantiated only under MOD10_SEGOUT_EN and maps codes 10..15 to blank (0000000).

Test Plan:
- Reset then free run: rst=0 for 1 edge, then rst=1, en=1, up_dn=1, 25 edges -> count 0,1,..,9,0,1,..; tc=1 exactly when count=9.
- Down count: load_val=3 with load=1 for 1 edge, then up_dn=0, en=1 -> count 3,2,1,0,9,8; tc=1 while count=0.
- Hold and priority: at count=5, en=0 for 3 edges -> count stays 5. Then load=1, en=1, load_val=7 -> count=7 next edge, with tc=0 during the load cycle.
- Illegal load: load_val=12, load=1 -> count=0 next edge.
- Mid-run reset: at count=6 drive rst=0 for one edge -> count=0. Release -> count 1,2,...
- Cascade: two instances, tens.en = units.tc, 100 edges from reset -> the pair reads 00..99 and wraps to 00. With MOD10_SEGOUT_EN, seg=1101101 when count=5.

Source files
------------

// File: rtl/mod10_pkg.sv
// Shared constants, direction encoding and seven-segment patterns for the decade counter.
package mod10_pkg;

  localparam int MOD10_MODULUS = 10;
  localparam int MOD10_WIDTH   = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Active-high segments, bit order gfedcba, digits 0..9
  localparam logic [6:0] SEG_PATTERNS [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; codes 10..15 are blanked.
module bcd_to_7seg
  import mod10_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (bcd)
      4'd0: seg = SEG_PATTERNS[0];
      4'd1: seg = SEG_PATTERNS[1];
      4'd2: seg = SEG_PATTERNS[2];
      4'd3: seg = SEG_PATTERNS[3];
      4'd4: seg = SEG_PATTERNS[4];
      4'd5: seg = SEG_PATTERNS[5];
      4'd6: seg = SEG_PATTERNS[6];
      4'd7: seg = SEG_PATTERNS[7];
      4'd8: seg = SEG_PATTERNS[8];
      4'd9: seg = SEG_PATTERNS[9];
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/mod10_counter.sv
// Decade up/down counter with synchronous load and combinational terminal count.
// Define MOD10_SEGOUT_EN to add a registered seven-segment output aligned with count.
module mod10_counter
  import mod10_pkg::*;
#(
  parameter int MODULUS = MOD10_MODULUS,
  parameter int WIDTH   = MOD10_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
`ifdef MOD10_SEGOUT_EN
  ,
  output logic [6:0]       seg
`endif
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_d, count_q;
  dir_e             dir;
  logic             at_top, at_bottom;

  assign dir       = dir_e'(up_dn);
  assign at_top    = (count_q == LAST);
  assign at_bottom = (count_q == '0);

  // Out-of-range states fall back to 0 on any enabled edge.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val <= LAST) ? load_val : '0;
    end else if (en) begin
      if (count_q > LAST) begin
        count_d = '0;
      end else if (dir == DIR_UP) begin
        count_d = at_top ? '0 : count_q + 1'b1;
      end else begin
        count_d = at_bottom ? LAST : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = en & ~load & (((dir == DIR_UP) & at_top) | ((dir == DIR_DOWN) & at_bottom));

`ifdef MOD10_SEGOUT_EN
  logic [6:0] seg_d, seg_q;

  // Decoding the next count keeps seg in step with count after each edge.
  bcd_to_7seg u_dec (
    .bcd (4'(count_d)),
    .seg (seg_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q <= SEG_PATTERNS[0];
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;
`endif

endmodule

// File: tb/tb_mod10_counter.sv
// Scoreboard bench for mod10_counter: directed test-plan sequences, random traffic and a two-digit cascade.
module tb_mod10_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc;

  logic       c_rst;
  logic [3:0] u_count, t_count;
  logic       u_tc, t_tc;

`ifdef MOD10_SEGOUT_EN
  logic [6:0] seg, u_seg, t_seg;
`endif

  always #5 clk = ~clk;

  mod10_counter dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count), .tc(tc)
`ifdef MOD10_SEGOUT_EN
    , .seg(seg)
`endif
  );

  mod10_counter units (
    .clk(clk), .rst(c_rst), .en(1'b1), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .count(u_count), .tc(u_tc)
`ifdef MOD10_SEGOUT_EN
    , .seg(u_seg)
`endif
  );

  mod10_counter tens (
    .clk(clk), .rst(c_rst), .en(u_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
    .count(t_count), .tc(t_tc)
`ifdef MOD10_SEGOUT_EN
    , .seg(t_seg)
`endif
  );

  typedef struct {
    int kind;  // 0: single counter, 1: cascade pair
    int val;
    int flag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: plain integer arithmetic on the decimal digit
  int   mc;
  bit   mvalid = 0;
  int   pair;

`ifdef MOD10_SEGOUT_EN
  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction
`endif

  task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
    exp_t it;
    @(negedge clk);
    rst = r; en = e; up_dn = u; load = l; load_val = 4'(lv);
    if (mvalid) begin
      it.kind = 0;
      it.val  = mc;
      it.flag = (e && !l && ((u && mc == 9) || (!u && mc == 0))) ? 1 : 0;
      q.push_back(it);
    end
    if (!r) begin
      mc = 0;
    end else if (l) begin
      mc = (lv < 10) ? lv : 0;
    end else if (e) begin
      mc = u ? (mc + 1) % 10 : (mc + 9) % 10;
    end
    if (!r) mvalid = 1;
  endtask

  task automatic cstep(input bit r);
    exp_t it;
    @(negedge clk);
    c_rst = r;
    if (pair >= 0) begin
      it.kind = 1;
      it.val  = pair;
      it.flag = (pair == 99) ? 1 : 0;
      q.push_back(it);
    end
    pair = r ? (pair + 1) % 100 : 0;
  endtask

  // Monitor: compares every queued expectation just after the falling edge
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        if (it.kind == 0) begin
          checks++;
          if (int'(count) != it.val) begin
            errors++;
            $display("FAIL count: got %0d expected %0d at %0t", count, it.val, $time);
          end
          checks++;
          if (int'(tc) != it.flag) begin
            errors++;
            $display("FAIL tc: got %0d expected %0d (count %0d) at %0t", tc, it.flag, it.val, $time);
          end
`ifdef MOD10_SEGOUT_EN
          checks++;
          if (seg != pat(it.val)) begin
            errors++;
            $display("FAIL seg: got %b expected %b at %0t", seg, pat(it.val), $time);
          end
`endif
        end else begin
          checks++;
          if (int'(t_count) * 10 + int'(u_count) != it.val) begin
            errors++;
            $display("FAIL cascade: got %0d%0d expected %0d at %0t", t_count, u_count, it.val, $time);
          end
          checks++;
          if (int'(t_tc) != it.flag) begin
            errors++;
            $display("FAIL cascade_tc: got %0d expected %0d (pair %0d)", t_tc, it.flag, it.val);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
    c_rst = 1'b0; pair = -1;

    // Reset then free-running up count
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 25; i++) step(1, 1, 1, 0, 0);

    // Load 3 then count down through the wrap
    step(1, 0, 0, 1, 3);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0);

    // Hold at 5, then load beats enable
    step(1, 0, 1, 1, 5);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 7);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 9);
    step(1, 0, 1, 0, 0);

    // Illegal load values
    step(1, 1, 1, 1, 12);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 15);
    step(1, 0, 0, 1, 10);
    step(1, 0, 0, 0, 0);

    // Mid-run reset from 6
    step(1, 0, 1, 1, 6);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 5) == 0), $urandom_range(0, 15));
    end
    step(1, 0, 1, 0, 0);

    // Cascade: two digits from reset through 00..99 and back to 00
    cstep(0);
    for (int i = 0; i < 102; i++) cstep(1);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
